// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and the square-root controller states.
package fp32_pkg;

  localparam int m    = 8;
  localparam int n    = 23;
  localparam int BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_step.sv
// One restoring radix-2 square-root step: brings down two radicand bits and
// decides the next root bit by a trial subtraction of (root << 2) | 1.
module sqrt_step #(
  parameter int QW = fp32_pkg::n + 2,
  parameter int RW = QW + 3
) (
  input  logic [RW-1:0] rem,
  input  logic [QW-1:0] root,
  input  logic [1:0]    pair,
  output logic [RW-1:0] rem_next,
  output logic          root_bit
);

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;
  logic [RW-1:0] diff;
  logic          ge;

  assign shifted  = (rem << 2) | {{(RW-2){1'b0}}, pair};
  assign trial    = {{(RW-QW-2){1'b0}}, root, 2'b01};
  assign diff     = shifted - trial;
  assign ge       = shifted >= trial;
  assign rem_next = ge ? diff : shifted;
  assign root_bit = ge;

endmodule

// File: rtl/fpsqrt_iter.sv
// Iterative binary32 square root: specials resolve in one cycle, normal inputs
// run 25 restoring steps then a round-to-nearest-even cycle.
module fpsqrt_iter #(
  parameter int m = fp32_pkg::m,
  parameter int n = fp32_pkg::n
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [m+n:0]   x_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [m+n:0]   c_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           invalid_out
);
  import fp32_pkg::*;

  localparam int W    = m + n + 1;
  localparam int QW   = n + 2;
  localparam int RW   = QW + 3;
  localparam int RADW = 2 * QW;
  localparam int CW   = $clog2(QW);

  localparam logic [W-1:0] QNAN_W    = {1'b0, {m{1'b1}}, 1'b1, {(n-1){1'b0}}};
  localparam logic [W-1:0] PINF_W    = {1'b0, {m{1'b1}}, {n{1'b0}}};
  localparam logic [m-1:0] HALF_BIAS = m'((BIAS - 1) / 2);

  // Returns {carry, fraction}; q_lo holds the fraction bits followed by the round bit.
  function automatic logic [n:0] round_rne(input logic [n:0] q_lo, input logic sticky);
    logic         inc;
    logic [n-1:0] frac;
    logic         carry;
    inc   = q_lo[0] & (sticky | q_lo[1]);
    frac  = q_lo[n:1] + {{(n-1){1'b0}}, inc};
    carry = (&q_lo[n:1]) & inc;
    return {carry, frac};
  endfunction

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  rem;
  logic [RW-1:0]  rem_nx;
  logic [QW-1:0]  root;
  logic           root_bit;
  logic [RADW-1:0] rad;
  logic [m-1:0]   exp_q;
  logic [W-1:0]   res;
  logic           inv;

  logic           sign_in;
  logic [m-1:0]   exp_in;
  logic [n-1:0]   frac_in;
  logic           is_zero;
  logic           is_max;
  logic           special;
  logic [W-1:0]   spec_res;
  logic           spec_inv;
  logic [QW-1:0]  rad_top;
  logic [m-1:0]   exp_res;
  logic [n:0]     rnd;
  logic           accept;

  assign sign_in = x_in[W-1];
  assign exp_in  = x_in[W-2:n];
  assign frac_in = x_in[n-1:0];
  assign is_zero = (exp_in == '0);
  assign is_max  = &exp_in;
  assign special = is_zero | is_max | sign_in;
  assign accept  = in_valid && (state == IDLE);

  // Subnormals collapse into signed zero before anything else is decided.
  always_comb begin
    spec_res = '0;
    spec_inv = 1'b0;
    if (is_zero) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else if (is_max && !sign_in && frac_in == '0) begin
      spec_res = PINF_W;
    end else begin
      spec_res = QNAN_W;
      spec_inv = 1'b1;
    end
  end

  // An even biased exponent means an odd unbiased one: double the significand instead.
  assign rad_top = exp_in[0] ? {2'b01, frac_in} : {1'b1, frac_in, 1'b0};
  assign exp_res = (exp_in >> 1) + HALF_BIAS + {{(m-1){1'b0}}, exp_in[0]};

  sqrt_step #(.QW(QW), .RW(RW)) u_step (
    .rem      (rem),
    .root     (root),
    .pair     (rad[RADW-1:RADW-2]),
    .rem_next (rem_nx),
    .root_bit (root_bit)
  );

  assign rnd = round_rne(root[QW-2:0], |rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = special ? DONE : CALC;
      CALC:  if (cnt == CW'(QW - 1)) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      root  <= '0;
      rad   <= '0;
      exp_q <= '0;
      res   <= '0;
      inv   <= 1'b0;
    end else begin
      case (state)
        // capture
        IDLE: if (accept) begin
          if (special) begin
            res <= spec_res;
            inv <= spec_inv;
          end else begin
            rad   <= {rad_top, {QW{1'b0}}};
            exp_q <= exp_res;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
          end
        end
        // iterate
        CALC: begin
          rad  <= rad << 2;
          rem  <= rem_nx;
          root <= {root[QW-2:0], root_bit};
          cnt  <= cnt + 1'b1;
        end
        // round and pack
        ROUND: begin
          res <= {1'b0, exp_q + {{(m-1){1'b0}}, rnd[n]}, rnd[n-1:0]};
          inv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign c_out       = res;
  assign invalid_out = inv;

endmodule

// File: tb/tb_fpsqrt_iter.sv
// Directed and randomized bench for fpsqrt_iter against a real-valued sqrt model with RNE.
module tb_fpsqrt_iter;
  import fp32_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] c_out;
  logic        out_valid;
  logic        out_ready;
  logic        invalid_out;

  int checks = 0;
  int errors = 0;

  fpsqrt_iter #(.m(8), .n(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .x_in        (x_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .c_out       (c_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .invalid_out (invalid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact rules for specials, double-precision sqrt then RNE to 24 bits.
  function automatic void ref_sqrt(input logic [31:0] x, output logic [31:0] r,
                                   output logic inv, output int lat);
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] db;
    logic [63:0] rb;
    real         q;
    logic [23:0] fr;
    int          ex;
    e = x[30:23];
    f = x[22:0];
    inv = 1'b0;
    lat = 1;
    r = 32'h0;
    if (e == 8'h00) begin
      r = {x[31], 31'b0};
    end else if (x[31] || (e == 8'hFF && f != 23'h0)) begin
      r = QNAN;
      inv = 1'b1;
    end else if (e == 8'hFF) begin
      r = PINF;
    end else begin
      lat = 27;
      db = {1'b0, 11'(int'(e) - 127 + 1023), f, 29'b0};
      q  = $sqrt($bitstoreal(db));
      rb = $realtobits(q);
      fr = {1'b0, rb[51:29]};
      if (rb[28] && ((|rb[27:0]) || rb[29])) fr = fr + 24'd1;
      ex = int'(rb[62:52]) - 1023 + 127 + int'(fr[23]);
      r  = {rb[63], 8'(ex), fr[22:0]};
    end
  endfunction

  // Presents x, counts edges from the accepting edge (counted as 1) until out_valid.
  task automatic issue(input logic [31:0] x, output int lat);
    int w;
    @(negedge clk);
    x_in = x;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    x_in = $urandom;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_ov0"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] exp_c, input logic exp_inv,
                    input int exp_lat, input int hold, input string tag);
    int lat;
    issue(x, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_c"}, c_out, exp_c);
    check({tag, "_inv"}, {31'b0, invalid_out}, {31'b0, exp_inv});
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check({tag, "_hold"}, c_out, exp_c);
    end
    consume(tag);
  endtask

  task automatic op_model(input logic [31:0] x, input int hold, input string tag);
    logic [31:0] r;
    logic        inv;
    int          lat;
    ref_sqrt(x, r, inv, lat);
    op(x, r, inv, lat, hold, tag);
  endtask

  initial begin
    int lat;
    logic [31:0] x;
    rst = 1'b1;
    x_in = 32'h0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_rdy", {31'b0, in_ready}, 32'd1);
    check("rst_ov", {31'b0, out_valid}, 32'd0);
    check("rst_c", c_out, 32'h0);
    check("rst_inv", {31'b0, invalid_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op(32'h41C8_0000, 32'h40A0_0000, 1'b0, 27, 0, "sq25");
    op(32'h4000_0000, 32'h3FB5_04F3, 1'b0, 27, 0, "sq2");
    op(32'h4110_0000, 32'h4040_0000, 1'b0, 27, 2, "sq9");
    op(32'hBF80_0000, 32'h7FC0_0000, 1'b1, 1, 0, "neg1");
    op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 1, 0, "pinf");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, 0, "nzero");
    op(32'h0000_0001, 32'h0000_0000, 1'b0, 1, 0, "subn");
    op(32'h7FC0_0001, 32'h7FC0_0000, 1'b1, 1, 0, "nan");
    op(32'h8000_0005, 32'h8000_0000, 1'b0, 1, 0, "nsubn");
    op_model(32'h7F7F_FFFF, 0, "maxf");
    op_model(32'h0080_0000, 0, "minn");
    op_model(32'h407F_FFFF, 0, "near4");

    // Backpressure: result must hold, and a request meanwhile must be dropped.
    issue(32'h41C8_0000, lat);
    check("bp_lat", 32'(lat), 32'd27);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        x_in = 32'h4110_0000;
        in_valid = 1'b1;
      end
      if (i == 7) in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_c", c_out, 32'h40A0_0000);
      check("bp_rdy", {31'b0, in_ready}, 32'd0);
      check("bp_ov", {31'b0, out_valid}, 32'd1);
    end
    consume("bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_noq", {31'b0, out_valid}, 32'd0);
    end

    // Abort in the middle of the iteration.
    @(negedge clk);
    x_in = 32'h41C8_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ov", {31'b0, out_valid}, 32'd0);
    check("abort_rdy", {31'b0, in_ready}, 32'd1);
    check("abort_c", c_out, 32'h0);
    check("abort_inv", {31'b0, invalid_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op(32'h4080_0000, 32'h4000_0000, 1'b0, 27, 0, "post_rst");

    for (int i = 0; i < 1200; i++) begin
      x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      op_model(x, int'($urandom_range(0, 2)), "rnd_norm");
    end
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      op_model(x, int'($urandom_range(0, 1)), "rnd_any");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
